stream_demux_1ton: RTL and testbench

- Parametrised, registered, packet-aware successor to the combinational 1-to-8 demultiplexer.
- Routes a valid/ready data stream from one input to one of NUM_CH output channels.
- Channel is chosen by select on the first beat of a packet and locked until the last beat.
- One output register stage; full throughput; out-of-range selects are discarded and counted.

---
 rtl/stream_demux_1ton.sv | 115 +++++++++++
 tb/tb_stream_demux_1ton.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_1ton.sv
// Packet-aware 1-to-NUM_CH stream demultiplexer with a single registered output stage.
// The channel is locked on the first beat; out-of-range packets are swallowed and counted.
module stream_demux_1ton #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 8,
    parameter int SEL_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  select,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [SEL_W-1:0]  cur_sel,
    output logic              busy,
    output logic [7:0]        drop_count
);

    typedef enum logic {IDLE, PKT} state_t;

    localparam logic [SEL_W:0] NUM_CH_W = (SEL_W+1)'(NUM_CH);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  lock_sel_q, lock_sel_d;
    logic              drop_q, drop_d;
    logic              hold_vld_q, hold_vld_d;
    logic [SEL_W-1:0]  hold_ch_q, hold_ch_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    logic first_beat, sel_oob, dropping, held_ready, drain, accept;

    // Only the held channel's ready matters; everything else is ignored.
    always_comb begin
        held_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (hold_ch_q == SEL_W'(i)) held_ready = out_ready[i];
        end
    end

    assign first_beat = (state_q == IDLE);
    assign sel_oob    = ({1'b0, select} >= NUM_CH_W);
    assign dropping   = first_beat ? sel_oob : drop_q;
    assign drain      = hold_vld_q && held_ready;
    assign in_ready   = dropping || !hold_vld_q || held_ready;
    assign accept     = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        drop_d     = drop_q;
        hold_vld_d = hold_vld_q;
        hold_ch_d  = hold_ch_q;
        data_d     = data_q;
        last_d     = last_q;
        drop_cnt_d = drop_cnt_q;

        if (drain) hold_vld_d = 1'b0;

        if (accept) begin
            state_d = in_last ? IDLE : PKT;
            if (first_beat) begin
                lock_sel_d = select;
                drop_d     = sel_oob;
                if (sel_oob && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
            end
            // A reload in the drain cycle overrides the clear above: no bubble.
            if (!dropping) begin
                hold_vld_d = 1'b1;
                hold_ch_d  = first_beat ? select : lock_sel_q;
                data_d     = in_data;
                last_d     = in_last;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            lock_sel_q <= '0;
            drop_q     <= 1'b0;
            hold_vld_q <= 1'b0;
            hold_ch_q  <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
            drop_q     <= drop_d;
            hold_vld_q <= hold_vld_d;
            hold_ch_q  <= hold_ch_d;
            data_q     <= data_d;
            last_q     <= last_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_vld
        assign out_valid[g] = hold_vld_q && (hold_ch_q == SEL_W'(g));
    end

    assign out_data   = data_q;
    assign out_last   = last_q;
    assign cur_sel    = lock_sel_q;
    assign busy       = (state_q == PKT);
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Bench for stream_demux_1ton: directed scenarios on an 8-channel instance and
// drop/random-traffic scenarios on a 6-channel instance against a packet-level model.
module tb_stream_demux_1ton;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-channel instance
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid, in_last, in_ready;
    logic [2:0] select;
    logic [7:0] out_data;
    logic       out_last;
    logic [7:0] out_valid, out_ready;
    logic [2:0] cur_sel;
    logic       busy;
    logic [7:0] drop_count;

    // 6-channel instance
    logic       rst6;
    logic [7:0] in_data6;
    logic       in_valid6, in_last6, in_ready6;
    logic [2:0] select6;
    logic [7:0] out_data6;
    logic       out_last6;
    logic [5:0] out_valid6, out_ready6;
    logic [2:0] cur_sel6;
    logic       busy6;
    logic [7:0] drop_count6;

    stream_demux_1ton #(.DATA_W(8), .NUM_CH(8), .SEL_W(3)) dut (
        .clk(clk), .reset(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .select(select), .out_data(out_data), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .cur_sel(cur_sel), .busy(busy),
        .drop_count(drop_count)
    );

    stream_demux_1ton #(.DATA_W(8), .NUM_CH(6), .SEL_W(3)) dut6 (
        .clk(clk), .reset(rst6), .in_data(in_data6), .in_valid(in_valid6), .in_last(in_last6),
        .in_ready(in_ready6), .select(select6), .out_data(out_data6), .out_last(out_last6),
        .out_valid(out_valid6), .out_ready(out_ready6), .cur_sel(cur_sel6), .busy(busy6),
        .drop_count(drop_count6)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        int         ch;
        logic [7:0] d;
        logic       l;
    } beat_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst6 = 1'b1;
        in_valid = 0; in_last = 0; in_data = 0; select = 0; out_ready = 8'hFF;
        in_valid6 = 0; in_last6 = 0; in_data6 = 0; select6 = 0; out_ready6 = 6'h3F;
        repeat (2) tick();
        total_cnt++; if (out_valid !== 8'h00) $display("FAIL rst_out_valid got %h exp 00", out_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else pass_cnt++;
        total_cnt++; if (drop_count !== 8'd0) $display("FAIL rst_drop_count got %0d exp 0", drop_count); else pass_cnt++;
        total_cnt++; if (cur_sel !== 3'd0) $display("FAIL rst_cur_sel got %0d exp 0", cur_sel); else pass_cnt++;
        total_cnt++; if ({out_data, out_last} !== 9'd0) $display("FAIL rst_out_data got %h/%b exp 00/0", out_data, out_last); else pass_cnt++;
        rst = 1'b0; rst6 = 1'b0;
        tick();
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", in_ready); else pass_cnt++;
        total_cnt++; if (drop_count6 !== 8'd0) $display("FAIL rst_drop_count6 got %0d exp 0", drop_count6); else pass_cnt++;
    endtask

    task automatic test_three_beat();
        out_ready = 8'hFF;
        in_valid = 1; select = 3'd5; in_data = 8'h11; in_last = 0;
        #3;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL tb3_in_ready got %b exp 1", in_ready); else pass_cnt++;
        tick();
        total_cnt++; if ({out_valid, out_data, out_last, busy} !== {8'h20, 8'h11, 1'b0, 1'b1})
            $display("FAIL tb3_beat1 got v=%h d=%h l=%b b=%b exp v=20 d=11 l=0 b=1", out_valid, out_data, out_last, busy); else pass_cnt++;
        in_data = 8'h22;
        tick();
        total_cnt++; if ({out_valid, out_data, out_last, busy} !== {8'h20, 8'h22, 1'b0, 1'b1})
            $display("FAIL tb3_beat2 got v=%h d=%h l=%b b=%b exp v=20 d=22 l=0 b=1", out_valid, out_data, out_last, busy); else pass_cnt++;
        in_data = 8'h33; in_last = 1;
        tick();
        total_cnt++; if ({out_valid, out_data, out_last, busy} !== {8'h20, 8'h33, 1'b1, 1'b0})
            $display("FAIL tb3_beat3 got v=%h d=%h l=%b b=%b exp v=20 d=33 l=1 b=0", out_valid, out_data, out_last, busy); else pass_cnt++;
        in_valid = 0; in_last = 0;
        tick();
        total_cnt++; if (out_valid !== 8'h00) $display("FAIL tb3_drained got %h exp 00", out_valid); else pass_cnt++;
    endtask

    task automatic test_lock();
        in_valid = 1; select = 3'd6; in_data = 8'h61; in_last = 0;
        tick();
        total_cnt++; if ({out_valid, cur_sel} !== {8'h40, 3'd6}) $display("FAIL lock_beat1 got v=%h sel=%0d exp v=40 sel=6", out_valid, cur_sel); else pass_cnt++;
        select = 3'd2; in_data = 8'h62;
        tick();
        total_cnt++; if ({out_valid, out_data, cur_sel} !== {8'h40, 8'h62, 3'd6})
            $display("FAIL lock_beat2 got v=%h d=%h sel=%0d exp v=40 d=62 sel=6", out_valid, out_data, cur_sel); else pass_cnt++;
        in_data = 8'h63; in_last = 1;
        tick();
        total_cnt++; if ({out_valid, out_data, out_last, cur_sel, busy} !== {8'h40, 8'h63, 1'b1, 3'd6, 1'b0})
            $display("FAIL lock_beat3 got v=%h d=%h l=%b sel=%0d b=%b exp v=40 d=63 l=1 sel=6 b=0", out_valid, out_data, out_last, cur_sel, busy); else pass_cnt++;
        in_valid = 0; in_last = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0] chans [3];
        logic [7:0] expv;
        chans[0] = 3'd0; chans[1] = 3'd7; chans[2] = 3'd3;
        out_ready = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_last = 1; select = chans[i]; in_data = 8'hB0 + 8'(i);
            #3;
            total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready%0d got %b exp 1", i, in_ready); else pass_cnt++;
            tick();
            expv = 8'h01 << chans[i];
            total_cnt++; if ({out_valid, out_data, busy} !== {expv, 8'hB0 + 8'(i), 1'b0})
                $display("FAIL b2b_out%0d got v=%h d=%h b=%b exp v=%h d=%h b=0", i, out_valid, out_data, busy, expv, 8'hB0 + 8'(i)); else pass_cnt++;
        end
        in_valid = 0; in_last = 0;
        tick();
        total_cnt++; if (out_valid !== 8'h00) $display("FAIL b2b_drained got %h exp 00", out_valid); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        out_ready = 8'hEF;
        in_valid = 1; in_last = 1; select = 3'd4; in_data = 8'hA5;
        tick();
        total_cnt++; if ({out_valid, out_data} !== {8'h10, 8'hA5}) $display("FAIL bp_load got v=%h d=%h exp v=10 d=a5", out_valid, out_data); else pass_cnt++;
        select = 3'd1; in_data = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            #3;
            total_cnt++; if ({in_ready, out_valid, out_data} !== {1'b0, 8'h10, 8'hA5})
                $display("FAIL bp_stall%0d got rdy=%b v=%h d=%h exp rdy=0 v=10 d=a5", i, in_ready, out_valid, out_data); else pass_cnt++;
            tick();
        end
        out_ready = 8'hFF;
        #3;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_release_rdy got %b exp 1", in_ready); else pass_cnt++;
        tick();
        total_cnt++; if ({out_valid, out_data} !== {8'h02, 8'h5A}) $display("FAIL bp_reload got v=%h d=%h exp v=02 d=5a", out_valid, out_data); else pass_cnt++;
        in_valid = 0; in_last = 0;
        tick();
        total_cnt++; if (out_valid !== 8'h00) $display("FAIL bp_drained got %h exp 00", out_valid); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        out_ready = 8'hF7;
        in_valid = 1; in_last = 0; select = 3'd3; in_data = 8'hC3;
        tick();
        total_cnt++; if ({out_valid, busy} !== {8'h08, 1'b1}) $display("FAIL rmid_held got v=%h b=%b exp v=08 b=1", out_valid, busy); else pass_cnt++;
        in_valid = 0;
        #2 rst = 1'b1;
        #1;
        total_cnt++; if ({out_valid, busy} !== {8'h00, 1'b0}) $display("FAIL rmid_async got v=%h b=%b exp v=00 b=0", out_valid, busy); else pass_cnt++;
        #1 rst = 1'b0;
        out_ready = 8'hFF;
        in_valid = 1; in_last = 1; select = 3'd1; in_data = 8'h1E;
        tick();
        total_cnt++; if ({out_valid, out_data, cur_sel, busy} !== {8'h02, 8'h1E, 3'd1, 1'b0})
            $display("FAIL rmid_resample got v=%h d=%h sel=%0d b=%b exp v=02 d=1e sel=1 b=0", out_valid, out_data, cur_sel, busy); else pass_cnt++;
        in_valid = 0; in_last = 0;
        tick();
    endtask

    task automatic test_drop();
        out_ready6 = 6'h3F;
        in_valid6 = 1; select6 = 3'd7; in_data6 = 8'hD1; in_last6 = 0;
        #3;
        total_cnt++; if (in_ready6 !== 1'b1) $display("FAIL drop_rdy1 got %b exp 1", in_ready6); else pass_cnt++;
        tick();
        total_cnt++; if ({out_valid6, drop_count6, busy6, cur_sel6} !== {6'h00, 8'd1, 1'b1, 3'd7})
            $display("FAIL drop_beat1 got v=%h cnt=%0d b=%b sel=%0d exp v=00 cnt=1 b=1 sel=7", out_valid6, drop_count6, busy6, cur_sel6); else pass_cnt++;
        select6 = 3'd0; in_data6 = 8'hD2; in_last6 = 1;
        #3;
        total_cnt++; if (in_ready6 !== 1'b1) $display("FAIL drop_rdy2 got %b exp 1", in_ready6); else pass_cnt++;
        tick();
        total_cnt++; if ({out_valid6, drop_count6, busy6} !== {6'h00, 8'd1, 1'b0})
            $display("FAIL drop_beat2 got v=%h cnt=%0d b=%b exp v=00 cnt=1 b=0", out_valid6, drop_count6, busy6); else pass_cnt++;
        for (int i = 0; i < 300; i++) begin
            select6 = (i % 2 == 0) ? 3'd6 : 3'd7;
            tick();
            if (i == 0) begin
                total_cnt++; if (drop_count6 !== 8'd2) $display("FAIL drop_cnt_step got %0d exp 2", drop_count6); else pass_cnt++;
            end
        end
        in_valid6 = 0; in_last6 = 0;
        tick();
        total_cnt++; if ({out_valid6, drop_count6} !== {6'h00, 8'd255}) $display("FAIL drop_saturate got v=%h cnt=%0d exp v=00 cnt=255", out_valid6, drop_count6); else pass_cnt++;
    endtask

    // Random packets into the 6-channel instance; the model is the ordered list of
    // beats of every packet whose select is in range, plus a count of the others.
    task automatic test_random();
        logic [7:0] bd[$];
        logic       bl[$];
        logic       bf[$];
        logic [2:0] bs[$];
        beat_t      exp_q[$];
        beat_t      e;
        int         drops, idx, cycles, nbeats, exp_cnt;
        logic       acc;

        rst6 = 1'b1; in_valid6 = 0; in_last6 = 0;
        tick();
        rst6 = 1'b0;
        drops = 0;
        for (int p = 0; p < 80; p++) begin
            int sel, len;
            sel = $urandom_range(0, 7);
            len = $urandom_range(1, 4);
            if (sel >= 6) drops++;
            for (int b = 0; b < len; b++) begin
                logic [7:0] d;
                d = 8'($urandom);
                bd.push_back(d); bl.push_back(b == len - 1); bf.push_back(b == 0); bs.push_back(3'(sel));
                if (sel < 6) begin
                    e.ch = sel; e.d = d; e.l = (b == len - 1);
                    exp_q.push_back(e);
                end
            end
        end
        nbeats = bd.size();
        idx = 0; cycles = 0;
        while ((idx < nbeats || exp_q.size() > 0) && cycles < 5000) begin
            if (!in_valid6 && idx < nbeats && $urandom_range(0, 99) < 70) in_valid6 = 1;
            if (in_valid6) begin
                in_data6 = bd[idx];
                in_last6 = bl[idx];
                select6  = bf[idx] ? bs[idx] : 3'($urandom_range(0, 7));
            end
            out_ready6 = 6'($urandom);
            @(negedge clk);
            total_cnt++; if (!$onehot0(out_valid6)) $display("FAIL rnd_onehot got %b", out_valid6); else pass_cnt++;
            if ((out_valid6 & out_ready6) != 6'h00) begin
                total_cnt++;
                if (exp_q.size() == 0) $display("FAIL rnd_extra_beat got v=%h d=%h exp none", out_valid6, out_data6);
                else begin
                    e = exp_q.pop_front();
                    if ({out_valid6, out_data6, out_last6} !== {6'h01 << e.ch, e.d, e.l})
                        $display("FAIL rnd_beat got v=%h d=%h l=%b exp v=%h d=%h l=%b", out_valid6, out_data6, out_last6, 6'h01 << e.ch, e.d, e.l);
                    else pass_cnt++;
                end
            end
            acc = in_valid6 && in_ready6;
            tick();
            if (acc) begin
                idx++;
                in_valid6 = 0;
                in_last6  = 0;
            end
            cycles++;
        end
        in_valid6 = 0; out_ready6 = 6'h3F;
        tick();
        total_cnt++; if (idx != nbeats || exp_q.size() != 0)
            $display("FAIL rnd_complete got sent=%0d left=%0d exp sent=%0d left=0", idx, exp_q.size(), nbeats); else pass_cnt++;
        exp_cnt = (drops > 255) ? 255 : drops;
        total_cnt++; if (drop_count6 !== 8'(exp_cnt)) $display("FAIL rnd_drop_count got %0d exp %0d", drop_count6, exp_cnt); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_three_beat();
        test_lock();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_drop();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
